// File: rtl/divfix_seq.sv
// divfix_seq: sequential signed fixed-point divider.
// Divides a Q(WI1.WF1) dividend by a Q(WI2.WF2) divisor and returns a
// Q(WI0.WF0) quotient. Restoring division on magnitudes, one quotient bit
// per clock, QN = WI1+WF1+WF2+WF0 iterations plus one finishing cycle.
//
// Handshake: start is sampled on a rising edge only while busy=0. busy stays
// high from the edge after the accepted start until the finishing edge. done
// pulses for one cycle, with out/OVF/DZ updated in that same cycle. The result
// is then held until the next completion. busy is already low while done is
// high, so a new start can be accepted in the done cycle.
//
// Build option: define DIVFIX_SAT_EN to saturate out on overflow. Without it,
// out wraps to the low W0 bits of the signed result. OVF is asserted in both
// builds. Divide-by-zero always returns the saturated value with DZ=1 and OVF=1.
module divfix_seq #(
  parameter int WI1 = 4,
  parameter int WF1 = 4,
  parameter int WI2 = 4,
  parameter int WF2 = 4,
  parameter int WI0 = 8,
  parameter int WF0 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  output logic                 busy,
  output logic                 done,
  output logic [WI0+WF0-1:0]   out,
  output logic                 OVF,
  output logic                 DZ
);

  localparam int N1 = WI1 + WF1;           // dividend width
  localparam int N2 = WI2 + WF2;           // divisor width
  localparam int QN = WI1 + WF1 + WF2 + WF0; // iteration count / quotient width
  localparam int W0 = WI0 + WF0;           // output width
  localparam int DW = N2 + WF1;            // scaled divisor width
  localparam int CW = $clog2(QN + 1);      // iteration counter width
  localparam int LW = QN + W0 + 1;         // width wide enough for range checks

  localparam logic [W0-1:0] OUT_MAX = {1'b0, {(W0-1){1'b1}}};
  localparam logic [W0-1:0] OUT_MIN = {1'b1, {(W0-1){1'b0}}};
  localparam logic [LW-1:0] ONE_LW  = {{(LW-1){1'b0}}, 1'b1};
  // Largest magnitude a negative result may have, and a positive one.
  localparam logic [LW-1:0] LIM_NEG = ONE_LW << (W0 - 1);
  localparam logic [LW-1:0] LIM_POS = LIM_NEG - ONE_LW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Latched operands and iteration state
  logic [CW-1:0] cnt;
  logic [QN-1:0] acc;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [DW-1:0] rem;   // partial remainder, always < dreg
  logic [DW-1:0] dreg;  // scaled divisor magnitude
  logic          neg;   // operand signs differ
  logic          s1;    // dividend sign, selects the divide-by-zero value
  logic          dz;    // divisor was zero

  // Operand magnitudes. An N-bit unsigned value holds 2^(N-1), so the most
  // negative input converts exactly; the sign bit becomes the extra magnitude bit.
  logic [N1-1:0] mag1;
  logic [N2-1:0] mag2;
  logic [QN-1:0] n_init;
  logic [DW-1:0] d_init;

  // Restoring step signals
  logic [DW:0]   rem_sh;
  logic [DW:0]   rem_sub;
  logic          q_bit;

  // Finishing-cycle result signals
  logic [LW-1:0] m_w;
  logic [W0-1:0] res_lo;
  logic          fin_ovf;
  logic [W0-1:0] fin_out;

  // Magnitudes and scaled operands for the latch cycle
  always_comb begin
    mag1   = in1[N1-1] ? -in1 : in1;
    mag2   = in2[N2-1] ? -in2 : in2;
    n_init = {mag1, {(WF2+WF0){1'b0}}};
    d_init = {mag2, {WF1{1'b0}}};
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // The remainder stays below the divisor, so the borrow out of bit DW tells
  // whether the subtraction went negative.
  always_comb begin
    rem_sh  = {rem, acc[QN-1]};
    rem_sub = rem_sh - {1'b0, dreg};
    q_bit   = ~rem_sub[DW];
  end

  // Sign application, range check and divide-by-zero override
  always_comb begin
    m_w     = {{(LW-QN){1'b0}}, acc};
    res_lo  = neg ? -acc[W0-1:0] : acc[W0-1:0];
    fin_ovf = neg ? (m_w > LIM_NEG) : (m_w > LIM_POS);
    fin_out = res_lo;
`ifdef DIVFIX_SAT_EN
    if (fin_ovf) begin
      fin_out = neg ? OUT_MIN : OUT_MAX;
    end
`endif
    if (dz) begin
      fin_ovf = 1'b1;
      fin_out = s1 ? OUT_MIN : OUT_MAX;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Operand latch and per-cycle restoring iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      rem  <= '0;
      dreg <= '0;
      neg  <= 1'b0;
      s1   <= 1'b0;
      dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt  <= CW'(QN - 1);
            acc  <= n_init;
            rem  <= '0;
            dreg <= d_init;
            neg  <= in1[N1-1] ^ in2[N2-1];
            s1   <= in1[N1-1];
            dz   <= (in2 == '0);
          end
        end
        RUN: begin
          acc <= {acc[QN-2:0], q_bit};
          rem <= q_bit ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
          cnt <= cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: updated and announced in the finishing cycle, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      out  <= '0;
      OVF  <= 1'b0;
      DZ   <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        out <= fin_out;
        OVF <= fin_ovf;
        DZ  <= dz;
      end
    end
  end

endmodule
